// File: rtl/tl_pkg.sv
// TileLink-UL shared definitions: opcodes, beat math and arbiter states.
// Imported by the A-channel arbiter and the D-channel demux.
package tl_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] ARITH           = 3'd2;
  localparam logic [2:0] LOGIC           = 3'd3;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] HINT            = 3'd5;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  // Puts, arithmetic and logical atomics carry a data payload.
  function automatic logic tl_a_has_data(input logic [2:0] opcode);
    return (opcode == PUT_FULL) || (opcode == PUT_PARTIAL) ||
           (opcode == ARITH) || (opcode == LOGIC);
  endfunction

  // Beats in an A message; dataless messages are always one beat.
  function automatic logic [4:0] tl_num_beats(
    input logic [2:0] opcode,
    input logic [2:0] size,
    input logic [2:0] log2_bytes
  );
    logic [4:0] beats;
    beats = 5'd1;
    if (tl_a_has_data(opcode) && (size > log2_bytes))
      beats = 5'd1 << (size - log2_bytes);
    return beats;
  endfunction

endpackage

// File: rtl/tl_d_demux2.sv
// Stateless D-channel router: the top source bit picks the client.
// Each beat routes on its own, so multi-beat responses need no lock.
module tl_d_demux2
  import tl_pkg::*;
#(
  parameter int CSRC_BITS = 5,
  parameter int DATA_BITS = 64
) (
  input  logic                 out_d_valid,
  output logic                 out_d_ready,
  input  logic [2:0]           out_d_bits_opcode,
  input  logic [1:0]           out_d_bits_param,
  input  logic [2:0]           out_d_bits_size,
  input  logic [CSRC_BITS:0]   out_d_bits_source,
  input  logic                 out_d_bits_sink,
  input  logic                 out_d_bits_denied,
  input  logic [DATA_BITS-1:0] out_d_bits_data,
  input  logic                 out_d_bits_corrupt,

  input  logic                 in0_d_ready,
  output logic                 in0_d_valid,
  output logic [2:0]           in0_d_bits_opcode,
  output logic [1:0]           in0_d_bits_param,
  output logic [2:0]           in0_d_bits_size,
  output logic [CSRC_BITS-1:0] in0_d_bits_source,
  output logic                 in0_d_bits_sink,
  output logic                 in0_d_bits_denied,
  output logic [DATA_BITS-1:0] in0_d_bits_data,
  output logic                 in0_d_bits_corrupt,

  input  logic                 in1_d_ready,
  output logic                 in1_d_valid,
  output logic [2:0]           in1_d_bits_opcode,
  output logic [1:0]           in1_d_bits_param,
  output logic [2:0]           in1_d_bits_size,
  output logic [CSRC_BITS-1:0] in1_d_bits_source,
  output logic                 in1_d_bits_sink,
  output logic                 in1_d_bits_denied,
  output logic [DATA_BITS-1:0] in1_d_bits_data,
  output logic                 in1_d_bits_corrupt
);

  logic idx;

  assign idx = out_d_bits_source[CSRC_BITS];

  // Steer valid to the addressed client and take ready from it.
  always_comb begin
    in0_d_valid = out_d_valid & ~idx;
    in1_d_valid = out_d_valid & idx;
    out_d_ready = idx ? in1_d_ready : in0_d_ready;
  end

  assign in0_d_bits_opcode  = out_d_bits_opcode;
  assign in0_d_bits_param   = out_d_bits_param;
  assign in0_d_bits_size    = out_d_bits_size;
  assign in0_d_bits_source  = out_d_bits_source[CSRC_BITS-1:0];
  assign in0_d_bits_sink    = out_d_bits_sink;
  assign in0_d_bits_denied  = out_d_bits_denied;
  assign in0_d_bits_data    = out_d_bits_data;
  assign in0_d_bits_corrupt = out_d_bits_corrupt;

  assign in1_d_bits_opcode  = out_d_bits_opcode;
  assign in1_d_bits_param   = out_d_bits_param;
  assign in1_d_bits_size    = out_d_bits_size;
  assign in1_d_bits_source  = out_d_bits_source[CSRC_BITS-1:0];
  assign in1_d_bits_sink    = out_d_bits_sink;
  assign in1_d_bits_denied  = out_d_bits_denied;
  assign in1_d_bits_data    = out_d_bits_data;
  assign in1_d_bits_corrupt = out_d_bits_corrupt;

endmodule

// File: rtl/tl_a_arbiter_2to1.sv
// Two-client TileLink-UL arbiter onto one manager port.
// Round-robin A grant with hold/burst locking; D routed by source MSB.
module tl_a_arbiter_2to1
  import tl_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int CSRC_BITS  = 5,
  parameter int ADDR_BITS  = 32
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    in0_a_valid,
  output logic                    in0_a_ready,
  input  logic [2:0]              in0_a_bits_opcode,
  input  logic [2:0]              in0_a_bits_param,
  input  logic [2:0]              in0_a_bits_size,
  input  logic [CSRC_BITS-1:0]    in0_a_bits_source,
  input  logic [ADDR_BITS-1:0]    in0_a_bits_address,
  input  logic [DATA_BYTES-1:0]   in0_a_bits_mask,
  input  logic [DATA_BYTES*8-1:0] in0_a_bits_data,
  input  logic                    in0_a_bits_corrupt,

  input  logic                    in1_a_valid,
  output logic                    in1_a_ready,
  input  logic [2:0]              in1_a_bits_opcode,
  input  logic [2:0]              in1_a_bits_param,
  input  logic [2:0]              in1_a_bits_size,
  input  logic [CSRC_BITS-1:0]    in1_a_bits_source,
  input  logic [ADDR_BITS-1:0]    in1_a_bits_address,
  input  logic [DATA_BYTES-1:0]   in1_a_bits_mask,
  input  logic [DATA_BYTES*8-1:0] in1_a_bits_data,
  input  logic                    in1_a_bits_corrupt,

  output logic                    out_a_valid,
  input  logic                    out_a_ready,
  output logic [2:0]              out_a_bits_opcode,
  output logic [2:0]              out_a_bits_param,
  output logic [2:0]              out_a_bits_size,
  output logic [CSRC_BITS:0]      out_a_bits_source,
  output logic [ADDR_BITS-1:0]    out_a_bits_address,
  output logic [DATA_BYTES-1:0]   out_a_bits_mask,
  output logic [DATA_BYTES*8-1:0] out_a_bits_data,
  output logic                    out_a_bits_corrupt,

  input  logic                    in0_d_ready,
  output logic                    in0_d_valid,
  output logic [2:0]              in0_d_bits_opcode,
  output logic [1:0]              in0_d_bits_param,
  output logic [2:0]              in0_d_bits_size,
  output logic [CSRC_BITS-1:0]    in0_d_bits_source,
  output logic                    in0_d_bits_sink,
  output logic                    in0_d_bits_denied,
  output logic [DATA_BYTES*8-1:0] in0_d_bits_data,
  output logic                    in0_d_bits_corrupt,

  input  logic                    in1_d_ready,
  output logic                    in1_d_valid,
  output logic [2:0]              in1_d_bits_opcode,
  output logic [1:0]              in1_d_bits_param,
  output logic [2:0]              in1_d_bits_size,
  output logic [CSRC_BITS-1:0]    in1_d_bits_source,
  output logic                    in1_d_bits_sink,
  output logic                    in1_d_bits_denied,
  output logic [DATA_BYTES*8-1:0] in1_d_bits_data,
  output logic                    in1_d_bits_corrupt,

  input  logic                    out_d_valid,
  output logic                    out_d_ready,
  input  logic [2:0]              out_d_bits_opcode,
  input  logic [1:0]              out_d_bits_param,
  input  logic [2:0]              out_d_bits_size,
  input  logic [CSRC_BITS:0]      out_d_bits_source,
  input  logic                    out_d_bits_sink,
  input  logic                    out_d_bits_denied,
  input  logic [DATA_BYTES*8-1:0] out_d_bits_data,
  input  logic                    out_d_bits_corrupt
);

  localparam int         LOG2_BYTES = $clog2(DATA_BYTES);
  localparam logic [2:0] LOG2_B3    = 3'(LOG2_BYTES);

  arb_state_t state, state_n;
  logic       rr, rr_n;
  logic       owner, owner_n;
  logic [3:0] beat_cnt, beat_cnt_n;

  logic       grant;
  logic       sel_valid;
  logic       fire;
  logic [4:0] beats;

  // Pick the client driving the manager port this cycle.
  always_comb begin
    grant = rr;
    unique case (state)
      IDLE: begin
        if (in0_a_valid && !in1_a_valid)
          grant = 1'b0;
        else if (in1_a_valid && !in0_a_valid)
          grant = 1'b1;
        else
          grant = rr;
      end
      HOLD, BURST: grant = owner;
      default:     grant = rr;
    endcase
  end

  // Steer the grantee's A fields and handshake onto the manager port.
  always_comb begin
    sel_valid          = grant ? in1_a_valid : in0_a_valid;
    out_a_valid        = sel_valid & ~reset;
    in0_a_ready        = ~reset & ~grant & out_a_ready;
    in1_a_ready        = ~reset & grant & out_a_ready;
    out_a_bits_opcode  = grant ? in1_a_bits_opcode : in0_a_bits_opcode;
    out_a_bits_param   = grant ? in1_a_bits_param : in0_a_bits_param;
    out_a_bits_size    = grant ? in1_a_bits_size : in0_a_bits_size;
    out_a_bits_source  = grant ? {1'b1, in1_a_bits_source}
                               : {1'b0, in0_a_bits_source};
    out_a_bits_address = grant ? in1_a_bits_address : in0_a_bits_address;
    out_a_bits_mask    = grant ? in1_a_bits_mask : in0_a_bits_mask;
    out_a_bits_data    = grant ? in1_a_bits_data : in0_a_bits_data;
    out_a_bits_corrupt = grant ? in1_a_bits_corrupt : in0_a_bits_corrupt;
  end

  assign fire  = out_a_valid & out_a_ready;
  assign beats = tl_num_beats(out_a_bits_opcode, out_a_bits_size, LOG2_B3);

  // Next-state logic; beat_cnt holds the beats still owed after a fire.
  always_comb begin
    state_n    = state;
    rr_n       = rr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    unique case (state)
      IDLE, HOLD: begin
        if (fire) begin
          if (beats != 5'd1) begin
            owner_n    = grant;
            beat_cnt_n = 4'(beats - 5'd1);
            state_n    = BURST;
          end else begin
            rr_n    = ~grant;
            state_n = IDLE;
          end
        end else if (sel_valid) begin
          owner_n = grant;
          state_n = HOLD;
        end else begin
          state_n = IDLE;
        end
      end
      BURST: begin
        if (fire) begin
          if (beat_cnt == 4'd1) begin
            beat_cnt_n = 4'd0;
            rr_n       = ~owner;
            state_n    = IDLE;
          end else begin
            beat_cnt_n = beat_cnt - 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr       <= 1'b0;
      owner    <= 1'b0;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  tl_d_demux2 #(
    .CSRC_BITS (CSRC_BITS),
    .DATA_BITS (DATA_BYTES*8)
  ) u_d_demux (
    .out_d_valid        (out_d_valid),
    .out_d_ready        (out_d_ready),
    .out_d_bits_opcode  (out_d_bits_opcode),
    .out_d_bits_param   (out_d_bits_param),
    .out_d_bits_size    (out_d_bits_size),
    .out_d_bits_source  (out_d_bits_source),
    .out_d_bits_sink    (out_d_bits_sink),
    .out_d_bits_denied  (out_d_bits_denied),
    .out_d_bits_data    (out_d_bits_data),
    .out_d_bits_corrupt (out_d_bits_corrupt),
    .in0_d_ready        (in0_d_ready),
    .in0_d_valid        (in0_d_valid),
    .in0_d_bits_opcode  (in0_d_bits_opcode),
    .in0_d_bits_param   (in0_d_bits_param),
    .in0_d_bits_size    (in0_d_bits_size),
    .in0_d_bits_source  (in0_d_bits_source),
    .in0_d_bits_sink    (in0_d_bits_sink),
    .in0_d_bits_denied  (in0_d_bits_denied),
    .in0_d_bits_data    (in0_d_bits_data),
    .in0_d_bits_corrupt (in0_d_bits_corrupt),
    .in1_d_ready        (in1_d_ready),
    .in1_d_valid        (in1_d_valid),
    .in1_d_bits_opcode  (in1_d_bits_opcode),
    .in1_d_bits_param   (in1_d_bits_param),
    .in1_d_bits_size    (in1_d_bits_size),
    .in1_d_bits_source  (in1_d_bits_source),
    .in1_d_bits_sink    (in1_d_bits_sink),
    .in1_d_bits_denied  (in1_d_bits_denied),
    .in1_d_bits_data    (in1_d_bits_data),
    .in1_d_bits_corrupt (in1_d_bits_corrupt)
  );

endmodule

// File: tb/tb_tl_a_arbiter_2to1.sv
// Directed bench for tl_a_arbiter_2to1.
// Inputs change 1ns after posedge; outputs sampled mid-cycle.
module tb_tl_a_arbiter_2to1;
  import tl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;

  logic        in0_a_valid, in0_a_ready;
  logic [2:0]  in0_a_bits_opcode, in0_a_bits_param, in0_a_bits_size;
  logic [4:0]  in0_a_bits_source;
  logic [31:0] in0_a_bits_address;
  logic [7:0]  in0_a_bits_mask;
  logic [63:0] in0_a_bits_data;
  logic        in0_a_bits_corrupt;

  logic        in1_a_valid, in1_a_ready;
  logic [2:0]  in1_a_bits_opcode, in1_a_bits_param, in1_a_bits_size;
  logic [4:0]  in1_a_bits_source;
  logic [31:0] in1_a_bits_address;
  logic [7:0]  in1_a_bits_mask;
  logic [63:0] in1_a_bits_data;
  logic        in1_a_bits_corrupt;

  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_bits_opcode, out_a_bits_param, out_a_bits_size;
  logic [5:0]  out_a_bits_source;
  logic [31:0] out_a_bits_address;
  logic [7:0]  out_a_bits_mask;
  logic [63:0] out_a_bits_data;
  logic        out_a_bits_corrupt;

  logic        in0_d_ready, in0_d_valid;
  logic [2:0]  in0_d_bits_opcode, in0_d_bits_size;
  logic [1:0]  in0_d_bits_param;
  logic [4:0]  in0_d_bits_source;
  logic        in0_d_bits_sink, in0_d_bits_denied, in0_d_bits_corrupt;
  logic [63:0] in0_d_bits_data;

  logic        in1_d_ready, in1_d_valid;
  logic [2:0]  in1_d_bits_opcode, in1_d_bits_size;
  logic [1:0]  in1_d_bits_param;
  logic [4:0]  in1_d_bits_source;
  logic        in1_d_bits_sink, in1_d_bits_denied, in1_d_bits_corrupt;
  logic [63:0] in1_d_bits_data;

  logic        out_d_valid, out_d_ready;
  logic [2:0]  out_d_bits_opcode, out_d_bits_size;
  logic [1:0]  out_d_bits_param;
  logic [5:0]  out_d_bits_source;
  logic        out_d_bits_sink, out_d_bits_denied, out_d_bits_corrupt;
  logic [63:0] out_d_bits_data;

  int vectors = 0;
  int miscompares = 0;

  tl_a_arbiter_2to1 dut (
    .clock              (clock),
    .reset              (reset),
    .in0_a_valid        (in0_a_valid),
    .in0_a_ready        (in0_a_ready),
    .in0_a_bits_opcode  (in0_a_bits_opcode),
    .in0_a_bits_param   (in0_a_bits_param),
    .in0_a_bits_size    (in0_a_bits_size),
    .in0_a_bits_source  (in0_a_bits_source),
    .in0_a_bits_address (in0_a_bits_address),
    .in0_a_bits_mask    (in0_a_bits_mask),
    .in0_a_bits_data    (in0_a_bits_data),
    .in0_a_bits_corrupt (in0_a_bits_corrupt),
    .in1_a_valid        (in1_a_valid),
    .in1_a_ready        (in1_a_ready),
    .in1_a_bits_opcode  (in1_a_bits_opcode),
    .in1_a_bits_param   (in1_a_bits_param),
    .in1_a_bits_size    (in1_a_bits_size),
    .in1_a_bits_source  (in1_a_bits_source),
    .in1_a_bits_address (in1_a_bits_address),
    .in1_a_bits_mask    (in1_a_bits_mask),
    .in1_a_bits_data    (in1_a_bits_data),
    .in1_a_bits_corrupt (in1_a_bits_corrupt),
    .out_a_valid        (out_a_valid),
    .out_a_ready        (out_a_ready),
    .out_a_bits_opcode  (out_a_bits_opcode),
    .out_a_bits_param   (out_a_bits_param),
    .out_a_bits_size    (out_a_bits_size),
    .out_a_bits_source  (out_a_bits_source),
    .out_a_bits_address (out_a_bits_address),
    .out_a_bits_mask    (out_a_bits_mask),
    .out_a_bits_data    (out_a_bits_data),
    .out_a_bits_corrupt (out_a_bits_corrupt),
    .in0_d_ready        (in0_d_ready),
    .in0_d_valid        (in0_d_valid),
    .in0_d_bits_opcode  (in0_d_bits_opcode),
    .in0_d_bits_param   (in0_d_bits_param),
    .in0_d_bits_size    (in0_d_bits_size),
    .in0_d_bits_source  (in0_d_bits_source),
    .in0_d_bits_sink    (in0_d_bits_sink),
    .in0_d_bits_denied  (in0_d_bits_denied),
    .in0_d_bits_data    (in0_d_bits_data),
    .in0_d_bits_corrupt (in0_d_bits_corrupt),
    .in1_d_ready        (in1_d_ready),
    .in1_d_valid        (in1_d_valid),
    .in1_d_bits_opcode  (in1_d_bits_opcode),
    .in1_d_bits_param   (in1_d_bits_param),
    .in1_d_bits_size    (in1_d_bits_size),
    .in1_d_bits_source  (in1_d_bits_source),
    .in1_d_bits_sink    (in1_d_bits_sink),
    .in1_d_bits_denied  (in1_d_bits_denied),
    .in1_d_bits_data    (in1_d_bits_data),
    .in1_d_bits_corrupt (in1_d_bits_corrupt),
    .out_d_valid        (out_d_valid),
    .out_d_ready        (out_d_ready),
    .out_d_bits_opcode  (out_d_bits_opcode),
    .out_d_bits_param   (out_d_bits_param),
    .out_d_bits_size    (out_d_bits_size),
    .out_d_bits_source  (out_d_bits_source),
    .out_d_bits_sink    (out_d_bits_sink),
    .out_d_bits_denied  (out_d_bits_denied),
    .out_d_bits_data    (out_d_bits_data),
    .out_d_bits_corrupt (out_d_bits_corrupt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic a0(input logic v, input logic [2:0] op,
                    input logic [2:0] sz, input logic [4:0] src);
    in0_a_valid       = v;
    in0_a_bits_opcode = op;
    in0_a_bits_size   = sz;
    in0_a_bits_source = src;
  endtask

  task automatic a1(input logic v, input logic [2:0] op,
                    input logic [2:0] sz, input logic [4:0] src);
    in1_a_valid       = v;
    in1_a_bits_opcode = op;
    in1_a_bits_size   = sz;
    in1_a_bits_source = src;
  endtask

  task automatic dbeat(input logic v, input logic [5:0] src,
                       input logic [63:0] d);
    out_d_valid       = v;
    out_d_bits_opcode = ACCESS_ACK_DATA;
    out_d_bits_size   = 3'd4;
    out_d_bits_source = src;
    out_d_bits_data   = d;
  endtask

  initial begin
    reset = 1'b1;
    a0(1'b1, GET, 3'd3, 5'd5);
    a1(1'b0, GET, 3'd3, 5'd3);
    in0_a_bits_param   = 3'd0;
    in0_a_bits_address = 32'h1000_0040;
    in0_a_bits_mask    = 8'hff;
    in0_a_bits_data    = 64'hAAAA_0000_0000_1111;
    in0_a_bits_corrupt = 1'b0;
    in1_a_bits_param   = 3'd0;
    in1_a_bits_address = 32'h2000_0080;
    in1_a_bits_mask    = 8'h0f;
    in1_a_bits_data    = 64'h5555_0000_0000_2222;
    in1_a_bits_corrupt = 1'b0;
    out_a_ready        = 1'b1;
    in0_d_ready        = 1'b1;
    in1_d_ready        = 1'b0;
    dbeat(1'b0, 6'h00, 64'h0);
    out_d_bits_param   = 2'd0;
    out_d_bits_sink    = 1'b0;
    out_d_bits_denied  = 1'b0;
    out_d_bits_corrupt = 1'b0;
    #3;
    chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
    chk("rst_in0_a_ready", 64'(in0_a_ready), 64'd0);
    chk("rst_in1_a_ready", 64'(in1_a_ready), 64'd0);
    chk("rst_in0_d_valid", 64'(in0_d_valid), 64'd0);
    chk("rst_in1_d_valid", 64'(in1_d_valid), 64'd0);
    in0_a_valid = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();

    // single Get on in0 plus a D reply to in0
    a0(1'b1, GET, 3'd3, 5'd5);
    dbeat(1'b1, 6'h05, 64'hDEAD_BEEF_0000_0001);
    #2;
    chk("t1_out_a_valid", 64'(out_a_valid), 64'd1);
    chk("t1_src", 64'(out_a_bits_source), 64'h05);
    chk("t1_addr", 64'(out_a_bits_address), 64'h1000_0040);
    chk("t1_in0_ready", 64'(in0_a_ready), 64'd1);
    chk("t1_in1_ready", 64'(in1_a_ready), 64'd0);
    chk("t1_in0_d_valid", 64'(in0_d_valid), 64'd1);
    chk("t1_in1_d_valid", 64'(in1_d_valid), 64'd0);
    chk("t1_in0_d_src", 64'(in0_d_bits_source), 64'd5);
    chk("t1_in0_d_data", in0_d_bits_data, 64'hDEAD_BEEF_0000_0001);
    chk("t1_out_d_ready", 64'(out_d_ready), 64'd1);
    cyc();
    in0_a_valid = 1'b0;
    dbeat(1'b0, 6'h00, 64'h0);

    // lone in1 Get flips rr back to 0
    a1(1'b1, GET, 3'd3, 5'd3);
    #2;
    chk("t1b_src", 64'(out_a_bits_source), 64'h23);
    chk("t1b_in1_ready", 64'(in1_a_ready), 64'd1);
    chk("t1b_mask", 64'(out_a_bits_mask), 64'h0f);
    cyc();

    // both valid, single beats: alternate 0,1,0,1
    a0(1'b1, GET, 3'd3, 5'd5);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t2_src", 64'(out_a_bits_source), (i % 2 == 0) ? 64'h05 : 64'h23);
      chk("t2_in0_ready", 64'(in0_a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      cyc();
    end

    // 8-beat PutFull on in0 locks out in1, with one idle gap
    a0(1'b1, PUT_FULL, 3'd6, 5'd7);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        in0_a_valid = 1'b0;
        #2;
        chk("t3_gap_valid", 64'(out_a_valid), 64'd0);
        chk("t3_gap_in1_ready", 64'(in1_a_ready), 64'd0);
        cyc();
        in0_a_valid = 1'b1;
      end
      #2;
      chk("t3_src", 64'(out_a_bits_source), 64'h07);
      chk("t3_in1_ready", 64'(in1_a_ready), 64'd0);
      chk("t3_in0_ready", 64'(in0_a_ready), 64'd1);
      cyc();
    end
    #2;
    chk("t3_after_src", 64'(out_a_bits_source), 64'h23);
    chk("t3_after_in0_ready", 64'(in0_a_ready), 64'd0);
    cyc();
    in0_a_valid = 1'b0;
    in1_a_valid = 1'b0;

    // HOLD: in0 presented alone with rr=1, stalled, in1 joins
    a0(1'b1, GET, 3'd3, 5'd5);
    cyc();
    out_a_ready = 1'b0;
    #2;
    chk("t4_first_src", 64'(out_a_bits_source), 64'h05);
    cyc();
    a1(1'b1, GET, 3'd3, 5'd3);
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("t4_hold_src", 64'(out_a_bits_source), 64'h05);
      chk("t4_hold_in1_ready", 64'(in1_a_ready), 64'd0);
      cyc();
    end
    out_a_ready = 1'b1;
    #2;
    chk("t4_fire_in0_ready", 64'(in0_a_ready), 64'd1);
    chk("t4_fire_src", 64'(out_a_bits_source), 64'h05);
    cyc();
    #2;
    chk("t4_rr_src", 64'(out_a_bits_source), 64'h23);
    cyc();
    in0_a_valid = 1'b0;
    in1_a_valid = 1'b0;

    // reset during a 4-beat burst, after 3 beats
    a0(1'b1, GET, 3'd3, 5'd5);
    cyc();
    a0(1'b1, PUT_FULL, 3'd5, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t5_burst_src", 64'(out_a_bits_source), 64'h07);
      cyc();
    end
    a1(1'b1, GET, 3'd3, 5'd3);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(out_a_valid), 64'd0);
    chk("t5_rst_in0_ready", 64'(in0_a_ready), 64'd0);
    chk("t5_rst_in1_ready", 64'(in1_a_ready), 64'd0);
    cyc();
    reset = 1'b0;
    a0(1'b1, GET, 3'd3, 5'd5);
    #2;
    chk("t5_post_src", 64'(out_a_bits_source), 64'h05);
    chk("t5_post_in0_ready", 64'(in0_a_ready), 64'd1);
    cyc();
    in0_a_valid = 1'b0;
    in1_a_valid = 1'b0;

    // back-to-back 2-beat AccessAckData: in1 then in0
    in1_d_ready = 1'b0;
    dbeat(1'b1, 6'h21, 64'h1111_2222_3333_4444);
    #2;
    chk("t6_in1_d_valid", 64'(in1_d_valid), 64'd1);
    chk("t6_in0_d_valid", 64'(in0_d_valid), 64'd0);
    chk("t6_stall_ready", 64'(out_d_ready), 64'd0);
    chk("t6_in1_d_src", 64'(in1_d_bits_source), 64'd1);
    cyc();
    in1_d_ready = 1'b1;
    #2;
    chk("t6_beat0_ready", 64'(out_d_ready), 64'd1);
    cyc();
    dbeat(1'b1, 6'h21, 64'h5555_6666_7777_8888);
    #2;
    chk("t6_beat1_in1_data", in1_d_bits_data, 64'h5555_6666_7777_8888);
    chk("t6_beat1_ready", 64'(out_d_ready), 64'd1);
    cyc();
    in0_d_ready = 1'b1;
    in1_d_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dbeat(1'b1, 6'h02, 64'(i + 9));
      #2;
      chk("t6_in0_d_valid", 64'(in0_d_valid), 64'd1);
      chk("t6_in1_d_idle", 64'(in1_d_valid), 64'd0);
      chk("t6_in0_d_src", 64'(in0_d_bits_source), 64'd2);
      chk("t6_in0_ready", 64'(out_d_ready), 64'd1);
      chk("t6_in0_data", in0_d_bits_data, 64'(i + 9));
      cyc();
    end
    dbeat(1'b0, 6'h00, 64'h0);
    #2;
    chk("t6_idle_in0", 64'(in0_d_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
